pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the PC and address datapath width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, meaning the number of return-address-stack entries (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port en  in  1  meaning advance enable; low = stall, PC holds.
REQ-007 SHALL have port pc_src  in  2  meaning next-PC select: 00 seq, 01 branch, 10 jalr, 11 trap.
REQ-008 SHALL have port imm_op  in  WIDTH  meaning the sign-extended immediate.
REQ-009 SHALL have port rs1  in  WIDTH  meaning the jalr base register value.
REQ-010 SHALL have port trap_vec  in  WIDTH  meaning the trap target address.
REQ-011 SHALL have port is_call  in  1  meaning the current instruction is a call (push return address).
REQ-012 SHALL have port is_ret  in  1  meaning the current jalr is a return (pop the stack).
REQ-013 SHALL have port pc  out  WIDTH  meaning the registered current PC.
REQ-014 SHALL have port pc_plus4  out  WIDTH  meaning pc+4, combinational.
REQ-015 SHALL have port misaligned  out  1  meaning a registered one-cycle flag: the last redirect target was misaligned.
REQ-016 SHALL have port ras_empty  out  1  meaning the return address stack holds no entries.

Function
REQ-017 SHALL compute the next PC as: seq = pc+4; branch = pc+imm_op; jalr = (rs1+imm_op) with bit0 cleared; trap = trap_vec.
REQ-018 SHALL wrap all additions modulo 2^WIDTH, with no overflow flag.
REQ-019 SHALL load the next PC into pc on a rising edge only when en=1, giving one-cycle latency from select to pc.
REQ-020 SHALL hold pc, misaligned and all stack state unchanged when en=0, regardless of the other inputs.
REQ-021 SHALL treat a branch or jalr target with bits[1:0] != 00 as misaligned: pc loads trap_vec and misaligned is high for exactly the following cycle.
REQ-022 SHALL never flag a trap-select target as misaligned.
REQ-023 SHALL, for is_ret=1 with pc_src=10 and a non-empty stack, use the stack top as the jalr target and pop it.
REQ-024 SHALL, for is_ret=1 with an empty stack, use rs1+imm_op and leave the stack empty (no underflow).
REQ-025 SHALL, for is_call=1 with en=1, push pc+4; when full, overwrite the oldest entry (circular), with the count saturating at RAS_DEPTH.
REQ-026 SHALL, when is_call and is_ret are both high, pop first and then push, so the top is replaced and the count is unchanged.
REQ-027 SHALL ignore is_ret when pc_src != 10.

Reset
REQ-028 SHALL, while rst is high, asynchronously force pc=RESET_VECTOR, misaligned=0, stack count=0 and ras_empty=1.
REQ-029 SHALL, on reset asserted mid-operation, discard all stack contents, with the first post-reset edge (en=1, seq) giving pc=RESET_VECTOR+4.

Configuration
REQ-030 SHALL, with macro PC_GEN_RAS_EN defined, implement the return address stack per REQ-023..026.
REQ-031 SHALL, without PC_GEN_RAS_EN, keep all ports, ignore is_call/is_ret, tie ras_empty=1, and take jalr from rs1+imm_op only.

Structure
REQ-032 SHALL take the pc_src encoding enum (PC_SEQ, PC_BRANCH, PC_JALR, PC_TRAP) and the constant INSTR_BYTES=4 from the shared package pc_pkg.
REQ-033 SHALL place the return address stack in one sub-module, pc_ras (push, pop, top, empty, full), instantiated only under PC_GEN_RAS_EN.

Verification
REQ-034 SHALL cover: reset with RESET_VECTOR=0x100, then 3 cycles of en=1 seq -> pc = 0x104, 0x108, 0x10C.
REQ-035 SHALL cover: pc=0x200, branch, imm_op=0xFFFFFFF0 -> pc=0x1F0; the same inputs with en=0 -> pc stays 0x200.
REQ-036 SHALL cover: jalr with rs1=0x301, imm_op=0 -> pc=0x300; with rs1=0x302 -> pc=trap_vec and misaligned=1 for one cycle.
REQ-037 SHALL cover: RAS_EN, 5 calls at pc=0x10,0x20,0x30,0x40,0x50 (DEPTH 4), then 5 returns -> targets 0x54,0x44,0x34,0x24, then rs1+imm_op, with ras_empty=1.
REQ-038 SHALL cover: pc=0xFFFFFFFC seq -> pc=0x0; simultaneous call+ret with stack top 0x84 at pc=0x90 -> pc=0x84, new top 0x94.
REQ-039 SHALL cover: rst asserted asynchronously between clock edges after 2 pushes -> pc=RESET_VECTOR immediately and ras_empty=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the PC generator: next-PC select encoding and
// instruction size.
package pc_pkg;

    // Next-PC source select, matches the 2-bit pc_src port encoding
    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_TRAP   = 2'b11
    } pc_src_e;

    localparam int unsigned INSTR_BYTES = 4;

    // A redirect target is misaligned when its low two bits are non-zero
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return address stack. A push when full overwrites the oldest
// entry; the count saturates at DEPTH. Simultaneous push and pop replace
// the top entry in place.
module pc_ras #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp;      // next free slot; top lives at sp-1
    logic [PW:0]      count;
    logic             pop_ok;
    logic [PW-1:0]    top_idx;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign top_idx = sp - PW'(1);
    assign top     = mem[top_idx];

    // Stack pointer and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
        end else if (push && pop_ok) begin
            sp    <= sp;
            count <= count;
        end else if (push) begin
            sp <= sp + PW'(1);
            if (!full) count <= count + (PW+1)'(1);
        end else if (pop_ok) begin
            sp    <= sp - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end

    // Entry storage; pop+push overwrites the current top slot
    always_ff @(posedge clk) begin
        if (push) mem[pop_ok ? top_idx : sp] <= din;
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator with sequential, branch, jalr and trap
// redirects plus misalignment trapping. Define PC_GEN_RAS_EN to enable the
// return address stack used for call/return prediction of jalr targets.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] imm_op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] trap_vec,
    input  logic             is_call,
    input  logic             is_ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misaligned,
    output logic             ras_empty
);

    pc_src_e          sel;
    logic [WIDTH-1:0] jalr_sum;
    logic [WIDTH-1:0] jalr_tgt;
    logic [WIDTH-1:0] next_pc;
    logic             next_mis;

    assign sel      = pc_src_e'(pc_src);
    assign pc_plus4 = pc + WIDTH'(INSTR_BYTES);
    assign jalr_sum = rs1 + imm_op;

`ifdef PC_GEN_RAS_EN
    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_top;

    assign ras_push = en && is_call;
    assign ras_pop  = en && is_ret && (sel == PC_JALR) && !ras_empty;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_plus4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  ()
    );

    // Returns with a non-empty stack take the predicted address
    assign jalr_tgt = (is_ret && !ras_empty) ? ras_top
                                             : {jalr_sum[WIDTH-1:1], 1'b0};
`else
    logic unused_ras;

    assign unused_ras = is_call ^ is_ret ^ (RAS_DEPTH == 0);
    assign ras_empty  = 1'b1;
    assign jalr_tgt   = {jalr_sum[WIDTH-1:1], 1'b0};
`endif

    // Next-PC select with misaligned branch/jalr targets diverted to trap_vec
    always_comb begin
        next_pc  = pc_plus4;
        next_mis = 1'b0;
        unique case (sel)
            PC_SEQ:    next_pc = pc_plus4;
            PC_BRANCH: next_pc = pc + imm_op;
            PC_JALR:   next_pc = jalr_tgt;
            PC_TRAP:   next_pc = trap_vec;
            default:   next_pc = pc_plus4;
        endcase
        if ((sel == PC_BRANCH || sel == PC_JALR) && is_misaligned(next_pc[1:0])) begin
            next_pc  = trap_vec;
            next_mis = 1'b1;
        end
    end

    // PC and misalignment flag register, advancing only when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_VECTOR;
            misaligned <= 1'b0;
        end else if (en) begin
            pc         <= next_pc;
            misaligned <= next_mis;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; expectations adapt to whether
// PC_GEN_RAS_EN is defined for the build.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] imm_op = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] trap_vec = '0;
    logic        is_call = 1'b0;
    logic        is_ret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        ras_empty;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

`ifdef PC_GEN_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    localparam logic [31:0] TV = 32'h8000_0000;

    pc_gen #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h100),
        .RAS_DEPTH    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pc_src     (pc_src),
        .imm_op     (imm_op),
        .rs1        (rs1),
        .trap_vec   (trap_vec),
        .is_call    (is_call),
        .is_ret     (is_ret),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned),
        .ras_empty  (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, sample 1 time unit after the edge
    task automatic step(input logic e, input logic [1:0] src, input logic [31:0] imm,
                        input logic [31:0] r1, input logic [31:0] tv,
                        input logic call, input logic ret);
        en = e; pc_src = src; imm_op = imm; rs1 = r1; trap_vec = tv;
        is_call = call; is_ret = ret;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_pc", pc, 32'h100);
        chk("rst_mis", {31'b0, misaligned}, 32'h0);
        chk("rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("rst_plus4", pc_plus4, 32'h104);
        rst = 1'b0;

        // Sequential advance
        step(1, 2'b00, 0, 0, TV, 0, 0); chk("seq1", pc, 32'h104);
        step(1, 2'b00, 0, 0, TV, 0, 0); chk("seq2", pc, 32'h108);
        step(1, 2'b00, 0, 0, TV, 0, 0); chk("seq3", pc, 32'h10C);

        // Trap to a misaligned vector is never flagged
        step(1, 2'b11, 0, 0, 32'h203, 0, 0);
        chk("trap_pc", pc, 32'h203);
        chk("trap_mis", {31'b0, misaligned}, 32'h0);

        // Branch backwards, stalled first
        step(1, 2'b11, 0, 0, 32'h200, 0, 0); chk("to200", pc, 32'h200);
        step(0, 2'b01, 32'hFFFF_FFF0, 0, TV, 0, 0); chk("br_stall", pc, 32'h200);
        step(1, 2'b01, 32'hFFFF_FFF0, 0, TV, 0, 0); chk("br_back", pc, 32'h1F0);

        // Misaligned branch
        step(1, 2'b01, 32'h2, 0, TV, 0, 0);
        chk("br_mis_pc", pc, TV);
        chk("br_mis_flag", {31'b0, misaligned}, 32'h1);
        step(1, 2'b00, 0, 0, TV, 0, 0);
        chk("br_mis_clr_pc", pc, TV + 32'h4);
        chk("br_mis_clr", {31'b0, misaligned}, 32'h0);

        // jalr: bit0 cleared, bit1 set traps
        step(1, 2'b10, 32'h0, 32'h301, TV, 0, 0);
        chk("jalr_pc", pc, 32'h300);
        chk("jalr_mis", {31'b0, misaligned}, 32'h0);
        step(1, 2'b10, 32'h0, 32'h302, TV, 0, 0);
        chk("jalr_mis_pc", pc, TV);
        chk("jalr_mis_flag", {31'b0, misaligned}, 32'h1);
        step(0, 2'b00, 0, 0, TV, 0, 0);
        chk("mis_hold", {31'b0, misaligned}, 32'h1);
        step(1, 2'b00, 0, 0, TV, 0, 0);
        chk("mis_drop", {31'b0, misaligned}, 32'h0);

        // Address wrap
        step(1, 2'b11, 0, 0, 32'hFFFF_FFFC, 0, 0);
        chk("wrap_plus4", pc_plus4, 32'h0);
        step(1, 2'b00, 0, 0, TV, 0, 0); chk("wrap_pc", pc, 32'h0);

        // Stalled call must not push
        step(0, 2'b00, 0, 0, TV, 1, 0);
        chk("stall_call", {31'b0, ras_empty}, 32'h1);

        // Five calls into a depth-4 stack
        step(1, 2'b11, 0, 0, 32'h10, 0, 0);
        step(1, 2'b11, 0, 0, 32'h20, 1, 0);
        step(1, 2'b11, 0, 0, 32'h30, 1, 0);
        step(1, 2'b11, 0, 0, 32'h40, 1, 0);
        step(1, 2'b11, 0, 0, 32'h50, 1, 0);
        step(1, 2'b11, 0, 0, 32'h1000, 1, 0);
        chk("calls_pc", pc, 32'h1000);
        chk("calls_empty", {31'b0, ras_empty}, RAS ? 32'h0 : 32'h1);
        // Return flag ignored outside jalr
        step(1, 2'b00, 0, 0, TV, 0, 1); chk("ret_ignored", pc, 32'h1004);
        step(1, 2'b10, 32'h4, 32'h600, TV, 0, 1); chk("ret1", pc, RAS ? 32'h54 : 32'h604);
        step(1, 2'b10, 32'h4, 32'h600, TV, 0, 1); chk("ret2", pc, RAS ? 32'h44 : 32'h604);
        step(1, 2'b10, 32'h4, 32'h600, TV, 0, 1); chk("ret3", pc, RAS ? 32'h34 : 32'h604);
        step(1, 2'b10, 32'h4, 32'h600, TV, 0, 1); chk("ret4", pc, RAS ? 32'h24 : 32'h604);
        chk("ret4_empty", {31'b0, ras_empty}, 32'h1);
        step(1, 2'b10, 32'h4, 32'h600, TV, 0, 1); chk("ret5", pc, 32'h604);
        chk("ret5_empty", {31'b0, ras_empty}, 32'h1);

        // Simultaneous call and return replaces the top
        step(1, 2'b11, 0, 0, 32'h80, 0, 0);
        step(1, 2'b11, 0, 0, 32'h90, 1, 0);
        chk("cr_setup", pc, 32'h90);
        step(1, 2'b10, 32'h0, 32'h600, TV, 1, 1);
        chk("cr_pc", pc, RAS ? 32'h84 : 32'h600);
        chk("cr_count", {31'b0, ras_empty}, RAS ? 32'h0 : 32'h1);
        step(1, 2'b10, 32'h0, 32'h700, TV, 0, 1);
        chk("cr_newtop", pc, RAS ? 32'h94 : 32'h700);
        chk("cr_empty", {31'b0, ras_empty}, 32'h1);

        // Asynchronous reset between edges discards the stack
        step(1, 2'b11, 0, 0, 32'h10, 1, 0);
        step(1, 2'b11, 0, 0, 32'h20, 1, 0);
        chk("pre_rst_empty", {31'b0, ras_empty}, RAS ? 32'h0 : 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h100);
        chk("async_rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("async_rst_mis", {31'b0, misaligned}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 2'b00, 0, 0, TV, 0, 0); chk("post_rst_seq", pc, 32'h104);
        step(1, 2'b10, 32'h0, 32'h700, TV, 0, 1); chk("post_rst_ret", pc, 32'h700);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
